sr_flipflop_bank: RTL and testbench
===================================

// Module: sr_flipflop_bank
//
// PURPOSE
//   Parametrised bank of WIDTH independent clocked S-R flip-flops. Each channel has:
//   - per-channel enable
//   - optional input stability filter (glitch rejection)
//   - a defined, selectable S=R=1 resolution (never X)
//   - rise/fall event pulses
//   A shared saturating counter records S=R=1 conflicts. Used for status/flag capture
//   in control paths where raw S/R strobes from several sources need latching.
//
// PARAMETERS
//   WIDTH          8      number of S-R channels (>=1)
//   FILTER         0      extra consecutive identical {s,r} samples required before acting (0..15)
//   CONFLICT_MODE  0      S=R=1 action: 0 hold, 1 set-dominant, 2 reset-dominant, 3 toggle
//   RESET_VAL      0      WIDTH-bit value loaded into q on reset
//   CNT_W          8      width of conflict_cnt
//
// PORTS
//   clk           in   1      clock; all state updates on rising edge
//   reset         in   1      reset, synchronous, active-high
//   s             in   WIDTH  per-channel set request
//   r             in   WIDTH  per-channel reset request
//   en            in   WIDTH  per-channel enable; 0 freezes channel
//   clr_cnt       in   1      synchronous clear of conflict_cnt
//   q             out  WIDTH  flip-flop state
//   q_bar         out  WIDTH  always exactly ~q
//   rise          out  WIDTH  1-cycle pulse: q[i] went 0->1 on the last edge
//   fall          out  WIDTH  1-cycle pulse: q[i] went 1->0 on the last edge
//   conflict      out  WIDTH  1-cycle pulse: a qualified S=R=1 was applied on the last edge
//   conflict_cnt  out  CNT_W  cycles with any conflict bit set; saturating
//
// BEHAVIOUR
// - Reset (sync, overrides en/clr_cnt, valid mid-operation):
//   - q=RESET_VAL, q_bar=~RESET_VAL
//   - rise=fall=conflict=0, conflict_cnt=0
//   - all filter counters 0, all sample history 2'b00
// - Per channel i, each edge with en[i]=1:
//   - Compare {s[i],r[i]} with stored history; equal -> stab[i]++ (saturate at FILTER), else stab[i]=0.
//   - Store the new pair as history.
//   - Pair is qualified when FILTER=0, or the same pair has been sampled on FILTER+1 consecutive edges.
// - Qualified action, registered into q on that same edge (visible next cycle):
//   - 00 hold
//   - 01 q=0
//   - 10 q=1
//   - 11 per CONFLICT_MODE; conflict[i]=1 for any mode, including hold
// - A stable qualified pair re-applies every edge. Toggle mode therefore toggles each cycle while 11 persists.
// - Latency: FILTER=0 -> q changes on the edge sampling s/r. FILTER=N -> on the (N+1)th identical sample.
// - en[i]=0: q[i] holds, stab[i]=0, history[i]=00, rise/fall/conflict[i]=0.
// - rise/fall/conflict: registered, high exactly one cycle per event, 0 otherwise. Toggle gives alternating rise/fall.
// - conflict_cnt: +1 on each edge where |conflict (new value) is 1, at most +1 per edge.
//   - Holds at 2^CNT_W-1.
//   - clr_cnt=1 -> 0, and clr_cnt wins over a same-edge increment.
// - No X ever driven on outputs. Channels are fully independent; no priority between channels.
//
// TESTING
// 1. reset=1 two edges, RESET_VAL=8'hA5 -> q=A5, q_bar=5A, pulses 0, cnt 0.
// 2. FILTER=0: s[0]=1 for 1 cycle -> q[0]=1 next cycle, rise[0] 1 cycle; then r[0]=1 -> q[0]=0, fall[0].
// 3. FILTER=2: s[1] high 2 cycles -> no change; high 3 cycles -> q[1]=1 after 3rd edge.
//    Glitch 1-0-1 -> no change.
// 4. s=r=1 on ch2 for 4 edges:
//    - mode0 hold; mode1 q=1; mode2 q=0; mode3 toggles 4 times
//    - conflict[2] high 4 cycles, cnt=4
// 5. CNT_W=2: 5 conflict cycles -> cnt saturates at 3. clr_cnt with a conflict on the same edge -> cnt=0.
// 6. en[3]=0 with s[3]=1 -> q[3] holds, no pulses. Reset asserted mid-toggle -> q=RESET_VAL next cycle.

Source files
------------

// File: rtl/sr_flipflop_bank.sv
// Bank of clocked S-R flip-flops with input filtering, defined S=R=1
// resolution, edge pulses and a saturating conflict counter.
module sr_flipflop_bank #(
    parameter int               WIDTH         = 8,
    parameter int               FILTER        = 0,
    parameter int               CONFLICT_MODE = 0,
    parameter logic [WIDTH-1:0] RESET_VAL     = '0,
    parameter int               CNT_W         = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] r,
    input  logic [WIDTH-1:0] en,
    input  logic             clr_cnt,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic [WIDTH-1:0] conflict,
    output logic [CNT_W-1:0] conflict_cnt
);

    localparam logic [3:0]       FILT = 4'(FILTER);
    localparam logic [CNT_W-1:0] CMAX = '1;

    logic [1:0]       pair   [WIDTH];
    logic [1:0]       hist   [WIDTH];
    logic [1:0]       hist_n [WIDTH];
    logic [3:0]       stab   [WIDTH];
    logic [3:0]       stab_n [WIDTH];
    logic [WIDTH-1:0] q_n;
    logic [WIDTH-1:0] conf_n;

    for (genvar g = 0; g < WIDTH; g++) begin : g_pair
        assign pair[g] = {s[g], r[g]};
    end

    assign q_bar = ~q;

    // Per-channel filter update and qualified S/R action
    always_comb begin
        q_n    = q;
        conf_n = '0;
        for (int i = 0; i < WIDTH; i++) begin
            hist_n[i] = 2'b00;
            stab_n[i] = 4'd0;
            if (en[i]) begin
                hist_n[i] = pair[i];
                if (pair[i] == hist[i])
                    stab_n[i] = (stab[i] == FILT) ? FILT : stab[i] + 4'd1;
                if (stab_n[i] == FILT) begin
                    case (pair[i])
                        2'b01: q_n[i] = 1'b0;
                        2'b10: q_n[i] = 1'b1;
                        2'b11: begin
                            conf_n[i] = 1'b1;
                            case (CONFLICT_MODE)
                                1:       q_n[i] = 1'b1;
                                2:       q_n[i] = 1'b0;
                                3:       q_n[i] = ~q[i];
                                default: q_n[i] = q[i];
                            endcase
                        end
                        default: q_n[i] = q[i];
                    endcase
                end
            end
        end
    end

    // State, history and pulse registers
    always_ff @(posedge clk) begin
        if (reset) begin
            q        <= RESET_VAL;
            rise     <= '0;
            fall     <= '0;
            conflict <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                hist[i] <= 2'b00;
                stab[i] <= 4'd0;
            end
        end else begin
            q        <= q_n;
            rise     <= ~q & q_n;
            fall     <= q & ~q_n;
            conflict <= conf_n;
            for (int i = 0; i < WIDTH; i++) begin
                hist[i] <= hist_n[i];
                stab[i] <= stab_n[i];
            end
        end
    end

    // Saturating count of cycles with any conflict; clear wins
    always_ff @(posedge clk) begin
        if (reset || clr_cnt)
            conflict_cnt <= '0;
        else if (|conf_n && conflict_cnt != CMAX)
            conflict_cnt <= conflict_cnt + 1'b1;
    end

endmodule

// File: tb/tb_sr_flipflop_bank.sv
// Randomized check of four sr_flipflop_bank configurations
// against a run-length reference model.
module tb_sr_flipflop_bank;

    logic       clk = 1'b0;
    logic       reset;
    logic       clr_cnt;
    logic [7:0] s, r, en;

    logic [7:0] q_a  [4];
    logic [7:0] qb_a [4];
    logic [7:0] ri_a [4];
    logic [7:0] fa_a [4];
    logic [7:0] co_a [4];
    logic [7:0] cn_a [4];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic int filt_of(int k);
        case (k)
            1:       return 2;
            3:       return 1;
            default: return 0;
        endcase
    endfunction

    function automatic int cw_of(int k);
        return (k == 2) ? 2 : 8;
    endfunction

    for (genvar k = 0; k < 4; k++) begin : g_dut
        localparam int CW = cw_of(k);
        logic [CW-1:0] cnt;
        sr_flipflop_bank #(
            .WIDTH(8),
            .FILTER(filt_of(k)),
            .CONFLICT_MODE(k),
            .RESET_VAL(8'hA5),
            .CNT_W(CW)
        ) u_dut (
            .clk(clk),
            .reset(reset),
            .s(s),
            .r(r),
            .en(en),
            .clr_cnt(clr_cnt),
            .q(q_a[k]),
            .q_bar(qb_a[k]),
            .rise(ri_a[k]),
            .fall(fa_a[k]),
            .conflict(co_a[k]),
            .conflict_cnt(cnt)
        );
        assign cn_a[k] = 8'(cnt);
    end

    // reference model: run length of identical samples per channel
    logic [7:0] mq  [4];
    logic [7:0] mri [4];
    logic [7:0] mfa [4];
    logic [7:0] mco [4];
    int         mcnt[4];
    logic [1:0] mlast[4][8];
    int         mrun [4][8];

    task automatic check(input string tag, input logic [7:0] got,
                         input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 4; k++) begin
            if (reset) begin
                mq[k]   = 8'hA5;
                mri[k]  = '0;
                mfa[k]  = '0;
                mco[k]  = '0;
                mcnt[k] = 0;
                for (int i = 0; i < 8; i++) begin
                    mlast[k][i] = 2'b00;
                    mrun[k][i]  = 1;
                end
            end else begin
                for (int i = 0; i < 8; i++) begin
                    logic       old, nq, c;
                    logic [1:0] p;
                    old = mq[k][i];
                    nq  = old;
                    c   = 1'b0;
                    p   = {s[i], r[i]};
                    if (!en[i]) begin
                        mlast[k][i] = 2'b00;
                        mrun[k][i]  = 1;
                    end else begin
                        if (p == mlast[k][i])
                            mrun[k][i] = (mrun[k][i] > 100) ? 100 : mrun[k][i] + 1;
                        else
                            mrun[k][i] = 1;
                        mlast[k][i] = p;
                        if (mrun[k][i] > filt_of(k)) begin
                            if (p == 2'b01) nq = 1'b0;
                            if (p == 2'b10) nq = 1'b1;
                            if (p == 2'b11) begin
                                c = 1'b1;
                                if (k == 1) nq = 1'b1;
                                if (k == 2) nq = 1'b0;
                                if (k == 3) nq = ~old;
                            end
                        end
                    end
                    mq[k][i]  = nq;
                    mri[k][i] = ~old & nq;
                    mfa[k][i] = old & ~nq;
                    mco[k][i] = c;
                end
                if (clr_cnt)
                    mcnt[k] = 0;
                else if (mco[k] != 0 && mcnt[k] < (1 << cw_of(k)) - 1)
                    mcnt[k]++;
            end
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("q%0d", k), q_a[k], mq[k]);
            check($sformatf("qbar%0d", k), qb_a[k], ~mq[k]);
            check($sformatf("rise%0d", k), ri_a[k], mri[k]);
            check($sformatf("fall%0d", k), fa_a[k], mfa[k]);
            check($sformatf("conf%0d", k), co_a[k], mco[k]);
            check($sformatf("cnt%0d", k), cn_a[k], 8'(mcnt[k]));
        end
    endtask

    logic [1:0] sp[8];

    initial begin
        reset   = 1'b1;
        clr_cnt = 1'b0;
        s       = '0;
        r       = '0;
        en      = '0;
        for (int i = 0; i < 8; i++) sp[i] = 2'b00;
        #2;
        repeat (2) cycle();

        reset = 1'b0;
        en    = 8'hFF;
        s     = 8'h01;
        cycle();
        s     = 8'h00;
        r     = 8'h01;
        cycle();
        r     = 8'h00;
        s     = 8'h02;
        repeat (3) cycle();
        s     = 8'h04;
        r     = 8'h04;
        repeat (5) cycle();
        clr_cnt = 1'b1;
        cycle();
        clr_cnt = 1'b0;
        en    = 8'hF7;
        s     = 8'h0C;
        r     = 8'h04;
        repeat (3) cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;

        for (int n = 0; n < 800; n++) begin
            for (int i = 0; i < 8; i++) begin
                if ($urandom_range(3) == 0) sp[i] = 2'($urandom_range(3));
                s[i]  = sp[i][1];
                r[i]  = sp[i][0];
                en[i] = ($urandom_range(7) != 0);
            end
            reset   = ($urandom_range(99) == 0);
            clr_cnt = ($urandom_range(15) == 0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
